master_in_port: RTL and testbench
=================================

Name: master_in_port

Overview:
- Master-side receiver for the serial bus read path. It is the counterpart to the slave transmit port.
- On a read request from the master core, it handshakes with the slave using a one-cycle `master_ready` pulse.
- It then deserialises the framed bit stream on `rx_data` (start bit, then data LSB-first) and presents the parallel word with a one-cycle done strobe.
- It also detects protocol errors: start-bit timeout, and `slave_tx_done` misalignment.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT_START before abort.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- rx_req  input  1  master core read request, level-sensitive, sampled in IDLE only
- slave_ready  input  1  slave has a word available
- rx_data  input  1  serial line from slave; idles high
- slave_tx_done  input  1  slave marks its last data bit
- master_ready  output  1  one-cycle grant pulse to slave
- data_out  output  DATA_WIDTH  last successfully received word
- rx_done  output  1  one-cycle strobe: data_out updated
- rx_busy  output  1  high in every state except IDLE
- rx_error  output  1  one-cycle strobe: frame aborted

Behaviour:
- Clocking and reset:
  - Single clock `clk`; reset is synchronous, active-high.
  - Reset values: master_ready=0, data_out=0, rx_done=0, rx_busy=0, rx_error=0, state=IDLE, counters=0, shift register=0.
  - Reset asserted mid-frame returns to IDLE on that edge. Partial data is discarded and data_out is unchanged from its reset value of 0.
- All outputs are registered.
- IDLE:
  - If rx_req=1 and slave_ready=1 at edge N, go to GRANT.
  - master_ready=1 during cycle N+1 only.
  - rx_req with slave_ready=0 is ignored and nothing is latched.
- GRANT: unconditionally go to WAIT_START at the next edge; master_ready returns to 0.
- WAIT_START:
  - Sample rx_data each edge. On rx_data=0 (start bit), go to RECEIVE with bit_cnt=0 and the timeout counter cleared.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT_CYCLES-1 without a start bit, go to IDLE with rx_error=1 for one cycle.
  - slave_tx_done is ignored in this state.
- RECEIVE:
  - Each edge, shift[bit_cnt] <= rx_data; data is LSB first; bit_cnt increments.
  - The first data bit is sampled one edge after the start bit.
  - slave_tx_done=1 while bit_cnt < DATA_WIDTH-1 is an early done: go to IDLE with a rx_error pulse; data_out is not updated.
  - At bit_cnt = DATA_WIDTH-1:
    - If slave_tx_done=1, go to DONE.
    - If slave_tx_done=0, go to IDLE with a rx_error pulse; data_out is not updated.
- DONE: data_out <= assembled word, rx_done=1 for this one cycle, then IDLE.
- Handshake back-to-back:
  - A new grant cannot be issued before IDLE is re-entered.
  - Minimum frame-to-frame spacing is DATA_WIDTH+4 cycles.
- Counter widths:
  - bit_cnt width = clog2(DATA_WIDTH).
  - Timeout counter width = clog2(TIMEOUT_CYCLES); saturates, no wrap.
- rx_done and rx_error are never high in the same cycle.

Decomposition:
- Shared bus package holds:
  - state encoding localparams: IDLE, GRANT, WAIT_START, RECEIVE, DONE
  - default DATA_WIDTH
  - idle-line level constant (1) and start-bit level constant (0)
  - these are reused by slave_out_port and master_out_port.
- One natural sub-module, `sipo_shift_reg` (serial-in parallel-out, LSB-first, with load-enable and clear). Its sibling transmit-side PISO is shared by the out ports.

Test Plan:
- Nominal: slave_ready=1, rx_req pulse.
  - Expect master_ready high exactly 1 cycle.
  - Drive start bit, then 8'hCC LSB-first (0,0,1,1,0,0,1,1) with slave_tx_done on the 8th bit.
  - Expect data_out=8'hCC with rx_done=1 one cycle after the last bit, and rx_busy low the next cycle.
- No slave data: rx_req=1 while slave_ready=0 for 20 cycles.
  - Expect master_ready never asserts and rx_busy stays 0.
- Timeout: grant issued, rx_data held 1.
  - Expect rx_error pulse after TIMEOUT_CYCLES in WAIT_START, state IDLE, data_out unchanged.
- Early done: slave_tx_done asserted on the 4th data bit of a frame.
  - Expect a rx_error pulse, no rx_done, data_out still holding the previous value (8'hCC).
- Reset mid-frame: synchronous reset asserted after 3 data bits.
  - Expect all outputs 0 on the next edge.
  - A subsequent full 8'hA5 frame then receives correctly.
- Back-to-back: two frames, 8'h3C then 8'hFF, with rx_req held high.
  - Expect two master_ready pulses at least DATA_WIDTH+4 cycles apart and both words delivered in order.

Source files
------------

// File: rtl/master_in_port_pkg.sv
// -----------------------------------------------------------------------------
// master_in_port_pkg
// Shared serial-bus definitions used by the receive and transmit ports:
//   - FSM state encoding (IDLE, GRANT, WAIT_START, RECEIVE, DONE)
//   - default frame data width
//   - line-level constants for the idle line and the start bit
//   - cnt_width(): width of a counter that must hold the values 0..n-1
// -----------------------------------------------------------------------------
package master_in_port_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // The serial line rests high; a frame begins with a single low bit.
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GRANT      = 3'd1,
        WAIT_START = 3'd2,
        RECEIVE    = 3'd3,
        DONE       = 3'd4
    } bus_state_e;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : master_in_port_pkg

// File: rtl/master_in_port_sipo.sv
// -----------------------------------------------------------------------------
// sipo_shift_reg
// Serial-in parallel-out register for the receive path. Each enabled edge
// writes bit_in into position bit_idx, so a frame sent LSB-first with an
// incrementing index assembles into its natural bit order.
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous, active-high; clears the word
//   clear    - synchronous clear at the start of each frame
//   load_en  - write bit_in into par_out[bit_idx] on this edge
//   bit_idx  - target bit position
//   bit_in   - serial input bit
//   par_out  - assembled parallel word
// -----------------------------------------------------------------------------
module sipo_shift_reg
    import master_in_port_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IDX_W      = cnt_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load_en,
    input  logic [IDX_W-1:0]      bit_idx,
    input  logic                  bit_in,
    output logic [DATA_WIDTH-1:0] par_out
);

    logic [DATA_WIDTH-1:0] par_q, par_d;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        par_d = par_q;
        if (clear) begin
            par_d = '0;
        end else if (load_en) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (bit_idx == IDX_W'(i)) begin
                    par_d[i] = bit_in;
                end
            end
        end
    end

    // NOTE: this word is a small register, not a RAM, so it is reset like any
    // other flop; storage arrays mapped to memory macros would not be.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            par_q <= '0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par_out = par_q;

endmodule : sipo_shift_reg

// File: rtl/master_in_port.sv
// -----------------------------------------------------------------------------
// master_in_port
// Master-side receiver for the serial bus read path. On a read request while
// the slave has data, it issues a one-cycle master_ready grant, waits for the
// start bit, deserialises DATA_WIDTH bits LSB-first and presents the word with
// a one-cycle rx_done strobe. Start-bit timeout and a slave_tx_done that does
// not coincide with the last data bit abort the frame with a rx_error strobe.
// Ports:
//   clk           - system clock, rising edge
//   reset         - synchronous, active-high reset
//   rx_req        - read request from the master core (sampled in IDLE)
//   slave_ready   - slave has a word available
//   rx_data       - serial line from the slave, idles high
//   slave_tx_done - slave marks its last data bit
//   master_ready  - one-cycle grant pulse to the slave
//   data_out      - last successfully received word
//   rx_done       - one-cycle strobe, data_out updated
//   rx_busy       - high whenever the FSM is outside IDLE
//   rx_error      - one-cycle strobe, frame aborted
// All outputs are registered.
// -----------------------------------------------------------------------------
module master_in_port
    import master_in_port_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_req,
    input  logic                  slave_ready,
    input  logic                  rx_data,
    input  logic                  slave_tx_done,
    output logic                  master_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rx_done,
    output logic                  rx_busy,
    output logic                  rx_error
);

    localparam int BIT_W = cnt_width(DATA_WIDTH);
    localparam int TMO_W = cnt_width(TIMEOUT_CYCLES);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = '1;

    bus_state_e            state_q, state_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;

    logic                  master_ready_q, master_ready_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  rx_done_q, rx_done_d;
    logic                  rx_busy_q, rx_busy_d;
    logic                  rx_error_q, rx_error_d;

    // Transition qualifiers shared by the next-state and output logic.
    logic                  abort;
    logic                  frame_ok;
    logic                  sipo_clear;
    logic                  sipo_load;
    logic [DATA_WIDTH-1:0] shift_word;
    logic [DATA_WIDTH-1:0] assembled;

    sipo_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (BIT_W)
    ) u_sipo (
        .clk     (clk),
        .reset   (reset),
        .clear   (sipo_clear),
        .load_en (sipo_load),
        .bit_idx (bit_cnt_q),
        .bit_in  (rx_data),
        .par_out (shift_word)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            tmo_cnt_q      <= '0;
            master_ready_q <= 1'b0;
            data_out_q     <= '0;
            rx_done_q      <= 1'b0;
            rx_busy_q      <= 1'b0;
            rx_error_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            master_ready_q <= master_ready_d;
            data_out_q     <= data_out_d;
            rx_done_q      <= rx_done_d;
            rx_busy_q      <= rx_busy_d;
            rx_error_q     <= rx_error_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        abort      = 1'b0;
        frame_ok   = 1'b0;
        sipo_clear = 1'b0;
        sipo_load  = 1'b0;

        unique case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                tmo_cnt_d = '0;
                // A request without slave data is simply not acted upon.
                if (rx_req && slave_ready) begin
                    state_d = GRANT;
                end
            end

            GRANT: begin
                state_d = WAIT_START;
            end

            WAIT_START: begin
                // slave_tx_done carries no meaning before the start bit.
                if (rx_data == START_BIT) begin
                    state_d    = RECEIVE;
                    bit_cnt_d  = '0;
                    tmo_cnt_d  = '0;
                    sipo_clear = 1'b1;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = IDLE;
                    tmo_cnt_d = '0;
                    abort     = 1'b1;
                end else if (tmo_cnt_q != TMO_MAX) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            RECEIVE: begin
                sipo_load = 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    // The slave must flag exactly the last bit as its last.
                    if (slave_tx_done) begin
                        state_d  = DONE;
                        frame_ok = 1'b1;
                    end else begin
                        state_d = IDLE;
                        abort   = 1'b1;
                    end
                end else if (slave_tx_done) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Outputs are registered, so they are computed from the transition being
    // taken this edge and become visible in the cycle of the new state.
    always_comb begin
        // The last data bit is written into the SIPO on the same edge the
        // word is published, so splice it in from the line directly.
        assembled                 = shift_word;
        assembled[DATA_WIDTH-1]   = rx_data;

        master_ready_d = (state_d == GRANT);
        rx_busy_d      = (state_d != IDLE);
        rx_done_d      = frame_ok;
        rx_error_d     = abort;
        data_out_d     = frame_ok ? assembled : data_out_q;
    end

    assign master_ready = master_ready_q;
    assign data_out     = data_out_q;
    assign rx_done      = rx_done_q;
    assign rx_busy      = rx_busy_q;
    assign rx_error     = rx_error_q;

endmodule : master_in_port

// File: tb/tb_master_in_port.sv
// -----------------------------------------------------------------------------
// tb_master_in_port
// Self-checking bench for master_in_port (DATA_WIDTH=8, TIMEOUT_CYCLES=64).
// Expected frame outcomes are queued when a frame is driven and compared when
// the DUT raises rx_done or rx_error.
// -----------------------------------------------------------------------------
module tb_master_in_port;

    localparam int DW      = 8;
    localparam int TMO     = 64;
    localparam int SPACING = DW + 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_req;
    logic          slave_ready;
    logic          rx_data;
    logic          slave_tx_done;
    logic          master_ready;
    logic [DW-1:0] data_out;
    logic          rx_done;
    logic          rx_busy;
    logic          rx_error;

    typedef struct {
        bit            err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   mr_cyc[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   mr_cnt   = 0;
    logic prev_mr  = 1'b0;
    exp_t e;

    master_in_port #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_req        (rx_req),
        .slave_ready   (slave_ready),
        .rx_data       (rx_data),
        .slave_tx_done (slave_tx_done),
        .master_ready  (master_ready),
        .data_out      (data_out),
        .rx_done       (rx_done),
        .rx_busy       (rx_busy),
        .rx_error      (rx_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and grant monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (master_ready) begin
                check("mr_width", prev_mr, 1'b0);
                mr_cnt++;
                mr_cyc.push_back(cyc);
            end
            if (rx_done || rx_error) begin
                check("done_err_excl", rx_done & rx_error, 1'b0);
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("evt_is_error", rx_error, e.err);
                    check(e.err ? "data_held" : "data_out", data_out, e.data);
                end
            end
        end
        prev_mr = master_ready;
    end

    task automatic wait_grant(input bit hold);
        bit got;
        got         = 1'b0;
        rx_req      = 1'b1;
        slave_ready = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (master_ready) got = 1'b1;
        end
        if (!hold) rx_req = 1'b0;
        if (!got) check("grant_timeout", 0, 1);
    endtask

    // Called in the GRANT cycle: start bit, then nbits data bits LSB-first,
    // with slave_tx_done on bit index done_at (-1 = never).
    task automatic send_bits(input logic [DW-1:0] d, input int nbits, input int done_at);
        tick();
        rx_data = 1'b0;
        tick();
        for (int i = 0; i < nbits; i++) begin
            rx_data       = d[i];
            slave_tx_done = (i == done_at);
            tick();
        end
        rx_data       = 1'b1;
        slave_tx_done = 1'b0;
    endtask

    initial begin
        int  n;
        bit  seen_mr;
        bit  seen_busy;

        reset         = 1'b1;
        rx_req        = 1'b0;
        slave_ready   = 1'b0;
        rx_data       = 1'b1;
        slave_tx_done = 1'b0;
        repeat (3) tick();
        check("rst_master_ready", master_ready, 0);
        check("rst_data_out", data_out, 0);
        check("rst_rx_done", rx_done, 0);
        check("rst_rx_busy", rx_busy, 0);
        check("rst_rx_error", rx_error, 0);
        reset = 1'b0;
        tick();

        // Nominal 8'hCC frame.
        sb.push_back('{err: 1'b0, data: 8'hCC});
        wait_grant(1'b0);
        send_bits(8'hCC, DW, DW - 1);
        check("nom_rx_done", rx_done, 1);
        check("nom_data_out", data_out, 8'hCC);
        check("nom_busy_in_done", rx_busy, 1);
        tick();
        check("nom_busy_after", rx_busy, 0);
        check("nom_done_pulse", rx_done, 0);

        // Request while the slave has no data.
        seen_mr     = 1'b0;
        seen_busy   = 1'b0;
        rx_req      = 1'b1;
        slave_ready = 1'b0;
        repeat (20) begin
            tick();
            seen_mr   |= master_ready;
            seen_busy |= rx_busy;
        end
        rx_req = 1'b0;
        check("noslave_mr", seen_mr, 0);
        check("noslave_busy", seen_busy, 0);

        // Start-bit timeout, line held idle.
        sb.push_back('{err: 1'b1, data: 8'hCC});
        wait_grant(1'b0);
        n = 0;
        for (int i = 0; i < 200 && !rx_error; i++) begin
            tick();
            n++;
        end
        check("tmo_latency", n, TMO + 1);
        check("tmo_idle", rx_busy, 0);
        check("tmo_data_out", data_out, 8'hCC);
        tick();
        check("tmo_err_pulse", rx_error, 0);

        // Early slave_tx_done on the 4th data bit.
        sb.push_back('{err: 1'b1, data: 8'hCC});
        wait_grant(1'b0);
        send_bits(8'h5A, 4, 3);
        check("early_err", rx_error, 1);
        check("early_no_done", rx_done, 0);
        check("early_idle", rx_busy, 0);
        tick();

        // Reset after 3 data bits, then a clean 8'hA5 frame.
        wait_grant(1'b0);
        send_bits(8'hFF, 3, -1);
        reset = 1'b1;
        tick();
        check("mid_rst_mr", master_ready, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_done", rx_done, 0);
        check("mid_rst_busy", rx_busy, 0);
        check("mid_rst_err", rx_error, 0);
        reset = 1'b0;
        tick();
        sb.push_back('{err: 1'b0, data: 8'hA5});
        wait_grant(1'b0);
        send_bits(8'hA5, DW, DW - 1);
        check("a5_data_out", data_out, 8'hA5);
        tick();

        // Back-to-back frames with rx_req held high.
        sb.push_back('{err: 1'b0, data: 8'h3C});
        sb.push_back('{err: 1'b0, data: 8'hFF});
        wait_grant(1'b1);
        send_bits(8'h3C, DW, DW - 1);
        check("b2b_first", data_out, 8'h3C);
        wait_grant(1'b0);
        send_bits(8'hFF, DW, DW - 1);
        check("b2b_second", data_out, 8'hFF);
        repeat (3) tick();
        if (mr_cyc.size() >= 2) begin
            check("b2b_spacing_ok", (mr_cyc[mr_cyc.size()-1] - mr_cyc[mr_cyc.size()-2]) >= SPACING, 1);
        end else begin
            check("b2b_grants", mr_cyc.size(), 2);
        end

        check("mr_pulses", mr_cnt, 7);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_master_in_port
